// File: rtl/uart_rx_fifo_if.sv
// Register-read port of the UART receiver: show-ahead byte, status and sticky error flags.
// Core side (master) drives the pop/clear strobes; the peripheral (slave) drives everything else.
interface uart_rx_fifo_if #(
    parameter int FIFO_DEPTH = 8
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic          rd_en;
    logic          clr_err;
    logic [7:0]    rd_data;
    logic          rx_valid;
    logic [CW-1:0] rx_count;
    logic          frame_err;
    logic          overrun;

    modport master (
        output rd_en, clr_err,
        input  rd_data, rx_valid, rx_count, frame_err, overrun
    );

    modport slave (
        input  rd_en, clr_err,
        output rd_data, rx_valid, rx_count, frame_err, overrun
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with show-ahead FIFO; byte visible the cycle after its stop-bit sample.
// No backpressure on the line: a byte arriving into a full FIFO is dropped and flags overrun.
module uart_rx_fifo #(
    parameter int CLK_DIV    = 217,
    parameter int FIFO_DEPTH = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           rxd,
    uart_rx_fifo_if.slave  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [15:0] DIV  = 16'(CLK_DIV);
    localparam logic [15:0] HALF = 16'(CLK_DIV / 2);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    logic          sync1, rxd_s;
    state_t        state, state_nxt;
    logic [15:0]   cnt, cnt_nxt;
    logic [2:0]    bit_idx, bit_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic          push, stop_err, expired;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          empty, full, do_push, do_pop, ovr_evt;
    logic          frame_err_q, overrun_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            sync1 <= rxd;
            rxd_s <= sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_nxt;
            shreg   <= shreg_nxt;
        end
    end

    // Counter expires on the edge where it reads 1, so a load of N samples N edges later.
    assign expired = (cnt == 16'd1);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bit_nxt   = bit_idx;
        shreg_nxt = shreg;
        push      = 1'b0;
        stop_err  = 1'b0;
        case (state)
            IDLE: begin
                if (!rxd_s) begin
                    cnt_nxt   = HALF;
                    state_nxt = START;
                end
            end
            START: begin
                if (!expired) begin
                    cnt_nxt = cnt - 16'd1;
                end else if (!rxd_s) begin
                    cnt_nxt   = DIV;
                    bit_nxt   = 3'd0;
                    state_nxt = DATA;
                end else begin
                    state_nxt = IDLE;
                end
            end
            DATA: begin
                if (!expired) begin
                    cnt_nxt = cnt - 16'd1;
                end else begin
                    shreg_nxt = {rxd_s, shreg[7:1]};
                    cnt_nxt   = DIV;
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                    end else begin
                        bit_nxt = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (!expired) begin
                    cnt_nxt = cnt - 16'd1;
                end else if (rxd_s) begin
                    push      = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    stop_err  = 1'b1;
                    state_nxt = BREAK;
                end
            end
            BREAK: begin
                if (rxd_s) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign empty   = (count == '0);
    assign full    = (count == CW'(FIFO_DEPTH));
    assign do_pop  = bus.rd_en && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign do_push = push && (!full || do_pop);
    assign ovr_evt = push && full && !do_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            mem[wr_ptr] <= shreg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= stop_err | (frame_err_q & ~bus.clr_err);
            overrun_q   <= ovr_evt  | (overrun_q   & ~bus.clr_err);
        end
    end

    assign bus.rd_data   = empty ? 8'h00 : mem[rd_ptr];
    assign bus.rx_valid  = !empty;
    assign bus.rx_count  = count;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: expected bytes queue up at send time, a monitor checks each pop.
module tb_uart_rx_fifo;
    localparam int DIV   = 16;
    localparam int DEPTH = 8;
    localparam int STOP_EDGE = 2 + DIV / 2 + 9 * DIV;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic rxd   = 1'b1;

    uart_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

    uart_rx_fifo #(.CLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .rxd   (rxd),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [7:0] sb [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop();
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
    endtask

    task automatic clear_err();
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
    endtask

    // Drives one frame; iteration c sets the inputs seen by edge c, edge 0 catching the start bit.
    task automatic send(input logic [7:0] b, input int stop_low, input bit pop_stop,
                        input bit tchk, input int abort);
        int total;
        int bp;
        total = DIV * (10 + stop_low);
        for (int c = 0; c < total; c++) begin
            if (c == abort) begin
                reset     = 1'b1;
                rxd       = 1'b1;
                bus.rd_en = 1'b0;
                repeat (3) tick();
                reset = 1'b0;
                return;
            end
            bp = c / DIV;
            if (bp == 0)                rxd = 1'b0;
            else if (bp <= 8)           rxd = b[bp-1];
            else if (bp <= 8 + stop_low) rxd = 1'b0;
            else                        rxd = 1'b1;
            bus.rd_en = pop_stop && (c == STOP_EDGE);
            tick();
            if (tchk && c == STOP_EDGE - 1) chk("valid_before_stop_edge", bus.rx_valid, 0);
            if (tchk && c == STOP_EDGE) begin
                chk("valid_after_stop_edge", bus.rx_valid, 1);
                chk("data_after_stop_edge", bus.rd_data, b);
                chk("count_after_stop_edge", bus.rx_count, 1);
            end
        end
        bus.rd_en = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_rd_data"},   bus.rd_data,   0);
        chk({tag, "_rx_valid"},  bus.rx_valid,  0);
        chk({tag, "_rx_count"},  bus.rx_count,  0);
        chk({tag, "_frame_err"}, bus.frame_err, 0);
        chk({tag, "_overrun"},   bus.overrun,   0);
    endtask

    // Monitor: every accepted pop must return the oldest outstanding expected byte.
    initial begin
        logic [7:0] exp;
        forever begin
            @(negedge clk);
            if (!reset && bus.rd_en && bus.rx_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL pop_unexpected actual=%02h required=none", bus.rd_data);
                end else begin
                    exp = sb.pop_front();
                    if (bus.rd_data !== exp) begin
                        failures++;
                        $display("FAIL pop_data actual=%02h required=%02h", bus.rd_data, exp);
                    end
                end
            end
        end
    end

    initial begin
        bus.rd_en   = 1'b0;
        bus.clr_err = 1'b0;
        repeat (4) tick();
        reset = 1'b0;
        tick();
        check_reset_state("reset");

        // Single byte with edge-exact visibility, then pop and pop-when-empty.
        sb.push_back(8'h55);
        send(8'h55, 0, 1'b0, 1'b1, -1);
        pop();
        chk("single_valid_after_pop", bus.rx_valid, 0);
        chk("single_data_after_pop", bus.rd_data, 8'h00);
        pop();
        chk("pop_empty_count", bus.rx_count, 0);

        // Glitch shorter than half a bit.
        rxd = 1'b0;
        repeat (4) tick();
        rxd = 1'b1;
        repeat (30) tick();
        chk("glitch_count", bus.rx_count, 0);
        chk("glitch_valid", bus.rx_valid, 0);
        chk("glitch_frame_err", bus.frame_err, 0);

        // Frame error, recovery, push+pop on empty, clear.
        send(8'hA3, 2, 1'b0, 1'b0, -1);
        chk("ferr_set", bus.frame_err, 1);
        chk("ferr_count", bus.rx_count, 0);
        sb.push_back(8'h3C);
        send(8'h3C, 0, 1'b1, 1'b0, -1);
        chk("push_pop_empty_count", bus.rx_count, 1);
        chk("ferr_sticky", bus.frame_err, 1);
        pop();
        clear_err();
        chk("ferr_cleared", bus.frame_err, 0);

        // Overrun: ninth byte dropped.
        for (int i = 1; i <= 9; i++) begin
            if (i <= DEPTH) sb.push_back(8'(i));
            send(8'(i), 0, 1'b0, 1'b0, -1);
        end
        chk("ovr_count", bus.rx_count, 8);
        chk("ovr_flag", bus.overrun, 1);
        chk("ovr_head", bus.rd_data, 8'h01);
        repeat (8) pop();
        chk("ovr_drained", bus.rx_count, 0);
        clear_err();
        chk("ovr_cleared", bus.overrun, 0);
        for (int i = 8'h0A; i <= 8'h0D; i++) begin
            sb.push_back(8'(i));
            send(8'(i), 0, 1'b0, 1'b0, -1);
        end
        chk("wrap_count", bus.rx_count, 4);
        repeat (4) pop();
        chk("wrap_drained", bus.rx_count, 0);

        // Push and pop on the same edge while full.
        for (int i = 0; i < DEPTH; i++) begin
            sb.push_back(8'(8'h10 + i));
            send(8'(8'h10 + i), 0, 1'b0, 1'b0, -1);
        end
        sb.push_back(8'h77);
        send(8'h77, 0, 1'b1, 1'b0, -1);
        chk("full_pp_count", bus.rx_count, 8);
        chk("full_pp_overrun", bus.overrun, 0);
        repeat (8) pop();
        chk("full_pp_drained", bus.rx_count, 0);

        // Reset during data bit 3 with a byte already buffered.
        sb.push_back(8'h5A);
        send(8'h5A, 0, 1'b0, 1'b0, -1);
        chk("pre_reset_count", bus.rx_count, 1);
        send(8'hF0, 0, 1'b0, 1'b0, 4 * DIV + 6);
        sb.delete();
        check_reset_state("midreset");
        repeat (200) tick();
        chk("midreset_no_push", bus.rx_count, 0);
        sb.push_back(8'h81);
        send(8'h81, 0, 1'b0, 1'b0, -1);
        chk("after_reset_count", bus.rx_count, 1);
        pop();
        tick();
        chk("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
